alu_operand_collector: RTL
==========================

Name: alu_operand_collector

Overview:
- Upstream stage of the 16-bit ALU. Collects one opcode and up to two operands from a single-word valid/ready input stream.
- Presents a stable {oc, a, b} bundle to the ALU with an output valid/ready handshake.
- Flags divide-by-zero before the ALU sees it, and counts completed issues.
- Sits between the datapath bus/sequencer and the combinational ALU.

Parameters:
DATA_WIDTH, 16, width of operands a/b and input data word
CNT_WIDTH, 16, width of issued-operation counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous abort of any partial or held operation
in_valid  input  1  input word valid
in_ready  output  1  collector can accept a word this cycle
in_data  input  DATA_WIDTH  operand word (A on first beat, B on second)
in_oc  input  3  opcode, sampled only on the A beat
out_valid  output  1  {oc,a,b} bundle valid for ALU
out_ready  input  1  consumer accepts bundle this cycle
oc  output  3  registered opcode to ALU
a  output  DATA_WIDTH  registered operand A
b  output  DATA_WIDTH  registered operand B
div_zero  output  1  registered: held op is DIV (3'b011) with b==0
op_count  output  CNT_WIDTH  number of bundles accepted by consumer

Behaviour:
- Opcode map: ADD 000, SUB 001, MUL 010, DIV 011, NOT 100, XOR 101, OR 110, AND 111. NOT is unary; all others are binary.
- States: IDLE (await A), WAIT_B (await B), FULL (bundle held).
- in_ready = 1 in IDLE and WAIT_B, 0 in FULL. It is combinational from state only and is not a function of out_ready.
- out_valid = 1 exactly when state==FULL. It is registered.
- IDLE, on in_valid: a<=in_data, oc<=in_oc.
  - If in_oc==NOT: b<=0, go to FULL.
  - Otherwise: go to WAIT_B.
- WAIT_B, on in_valid: b<=in_data, go to FULL. in_oc is ignored on this beat.
- FULL, on out_ready: go to IDLE, op_count<=op_count+1.
  - No input word is accepted in the same cycle (in_ready already 0).
  - oc/a/b keep their values after leaving FULL until overwritten.
- div_zero:
  - Loaded when entering FULL: 1 if oc==DIV and the B word being latched is 0; else 0.
  - Cleared on leaving FULL.
  - Informational only; the bundle is still issued normally.
- Latency:
  - Binary op: A at edge n, B at edge n+1 -> out_valid high after edge n+1.
  - Unary op: out_valid high after edge n.
  - Best-case binary throughput: one bundle per 3 cycles.
- Handshake: while out_valid=1 and out_ready=0, oc/a/b/div_zero/out_valid are stable.
- Gaps: in_valid low in IDLE/WAIT_B holds state indefinitely; partial A is retained.
- Priority: rst > flush > normal operation.
- flush (any state): next state IDLE, out_valid<=0, div_zero<=0. A word presented the same cycle is discarded, not latched. op_count is unchanged, even if out_ready was high in FULL (bundle counts as dropped). oc/a/b are not cleared.
- op_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Reset values: state IDLE, out_valid 0, oc 0, a 0, b 0, div_zero 0, op_count 0. in_ready reads 1 from the first cycle after reset.
- Reset mid-operation (WAIT_B or FULL): the partial or held bundle is lost and never issued.
- Width rules: all operand data is passed unmodified at DATA_WIDTH; no extension or truncation.

Test Plan:
- Reset, then ADD: A=0x0005 (oc=000), B=0x0003 on consecutive cycles -> out_valid after 2nd beat with oc=000, a=0x0005, b=0x0003. With out_ready=1 -> IDLE next cycle, op_count=1.
- NOT unary: A=0x00FF, oc=100 -> out_valid one cycle later, b=0x0000, in_ready=0. A further in_valid word is not accepted until out_ready.
- DIV by zero: A=0x0010, oc=011, B=0x0000 -> div_zero=1 with out_valid. After accept, div_zero=0. A repeat with B=0x0002 gives div_zero=0.
- Backpressure: bundle SUB 0x0009/0x0004 held with out_ready=0 for 5 cycles -> outputs stable, in_ready=0. out_ready=1 -> accepted once, op_count increments by exactly 1.
- Flush in WAIT_B with in_valid=1, in_data=0x1234 -> state IDLE, b not loaded, no out_valid. Flush in FULL with out_ready=1 -> out_valid=0, op_count unchanged.
- Preload op_count to 0xFFFF via 65535 unary issues (or force) -> next accept wraps to 0x0000. rst asserted in WAIT_B -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_operand_collector_if.sv
// rtl/alu_operand_collector_if.sv - operand stream in, {oc,a,b} bundle out
// slave is the collector side, master is the sequencer/ALU side.
interface alu_operand_collector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [2:0]            in_oc;
  logic                  out_valid;
  logic                  out_ready;
  logic [2:0]            oc;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  div_zero;
  logic [CNT_WIDTH-1:0]  op_count;

  modport slave (
    input  in_valid, in_data, in_oc, out_ready,
    output in_ready, out_valid, oc, a, b, div_zero, op_count
  );

  modport master (
    output in_valid, in_data, in_oc, out_ready,
    input  in_ready, out_valid, oc, a, b, div_zero, op_count
  );
endinterface

// File: rtl/alu_operand_collector.sv
// rtl/alu_operand_collector.sv - collects opcode + A/B beats into an ALU bundle
// IDLE takes A (and opcode), WAIT_B takes B, FULL holds the bundle until accepted.
module alu_operand_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  alu_operand_collector_if.slave bus
);

  localparam logic [2:0] OC_DIV = 3'b011;
  localparam logic [2:0] OC_NOT = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_B = 2'd1,
    S_FULL   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            oc_q, oc_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  div_zero_q, div_zero_d;
  logic                  out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;
  logic                  in_ready;
  logic                  a_beat, b_beat, issue;

  // flush wins over every transfer, so the qualifiers all include !flush
  assign a_beat = (state_q == S_IDLE)   && bus.in_valid  && !flush;
  assign b_beat = (state_q == S_WAIT_B) && bus.in_valid  && !flush;
  assign issue  = (state_q == S_FULL)   && bus.out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      oc_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      oc_q        <= oc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (bus.in_valid) state_d = (bus.in_oc == OC_NOT) ? S_FULL : S_WAIT_B;
        S_WAIT_B: if (bus.in_valid) state_d = S_FULL;
        S_FULL:   if (bus.out_ready) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    oc_d       = oc_q;
    a_d        = a_q;
    b_d        = b_q;
    op_count_d = op_count_q;
    if (a_beat) begin
      a_d  = bus.in_data;
      oc_d = bus.in_oc;
      if (bus.in_oc == OC_NOT) b_d = '0;
    end
    if (b_beat) b_d = bus.in_data;
    if (issue) op_count_d = op_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    // a unary entry into FULL comes from IDLE where div_zero is already 0
    if (b_beat) div_zero_d = (oc_q == OC_DIV) && (bus.in_data == '0);
    else        div_zero_d = (state_d == S_FULL) ? div_zero_q : 1'b0;
    out_valid_d = (state_d == S_FULL);
  end

  always_comb begin
    in_ready = (state_q != S_FULL);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.oc        = oc_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.op_count  = op_count_q;

endmodule
